// File: rtl/router_fifo_if.sv
// router_fifo_if: byte-stream bus between the router's synchroniser/destination
// side (master) and one per-port output FIFO (slave).
//   write_enb  : write request          read_enb   : read request
//   lfd_state  : header tag for data_in data_in    : byte to store
//   data_out   : registered read byte   full/empty : occupancy flags
//   pkt_active : packet being read out  ovf_err    : sticky misuse flag
interface router_fifo_if;
   logic       write_enb;
   logic       read_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic       pkt_active;
   logic       ovf_err;

   modport master (
      output write_enb, read_enb, lfd_state, data_in,
      input  data_out, full, empty, pkt_active, ovf_err
   );

   modport slave (
      input  write_enb, read_enb, lfd_state, data_in,
      output data_out, full, empty, pkt_active, ovf_err
   );
endinterface

// File: rtl/router_fifo.sv
// router_fifo: per-port output buffer of the 1x3 router. Stores {header tag, byte}
// entries and tracks packet boundaries on the read side.
// Ports:
//   clock      : single clock, rising edge
//   reset      : synchronous active-high reset (priority over soft_reset)
//   soft_reset : synchronous active-high flush, same effect as reset
//   bus        : router_fifo_if.slave (write/read requests, data, flags)
// Optional feature: define ROUTER_FIFO_ERR_CHK_EN to build the sticky ovf_err
// detector (write while full / read while empty); otherwise ovf_err is 0.
module router_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          soft_reset,
   router_fifo_if.slave  bus
);

   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = 9;
   localparam int unsigned CW = 6;

   logic [EW-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [7:0]    data_out_q, data_out_d;

   logic          flush;
   logic          full_c;
   logic          empty_c;
   logic          wr_acc;
   logic          rd_acc;
   logic [EW-1:0] rd_entry;

   assign flush   = reset | soft_reset;
   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty_c = (wr_ptr_q == rd_ptr_q);
   assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_acc  = bus.write_enb & ~full_c;
   assign rd_acc  = bus.read_enb & ~empty_c;
   assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

   // Storage array; contents survive reset, only the pointers are cleared.
   always_ff @(posedge clock) begin
      if (!flush && wr_acc) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
      end
   end

   // Next-state for pointers, read data and packet counter.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      pkt_cnt_d  = pkt_cnt_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + PW'(1);
         data_out_d = rd_entry[7:0];
         // Header carries payload length in [7:2]; +1 covers the parity byte.
         if (rd_entry[8]) begin
            pkt_cnt_d = CW'(rd_entry[7:2] + CW'(1));
         end else if (pkt_cnt_q != '0) begin
            pkt_cnt_d = pkt_cnt_q - CW'(1);
         end
      end
   end

   // State registers with synchronous reset/flush.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= 8'h00;
      end else if (soft_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pkt_cnt_q  <= '0;
         data_out_q <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pkt_cnt_q  <= pkt_cnt_d;
         data_out_q <= data_out_d;
      end
   end

`ifdef ROUTER_FIFO_ERR_CHK_EN
   logic ovf_q, ovf_d;

   // Sticky flag for any request the FIFO had to refuse.
   always_comb begin
      ovf_d = ovf_q | (bus.write_enb & full_c) | (bus.read_enb & empty_c);
   end

   always_ff @(posedge clock) begin
      if (flush) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf_err = ovf_q;
`else
   assign bus.ovf_err = 1'b0;
`endif

   assign bus.data_out   = data_out_q;
   assign bus.full       = full_c;
   assign bus.empty      = empty_c;
   assign bus.pkt_active = (pkt_cnt_q != '0);

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output buffer of the 1x3 router. It sits directly downstream of the register stage and captures the byte stream that stage drives out (header, payload, parity), one FIFO per destination port. It tags each header byte so the read side can track packet boundaries. The read side feeds the destination's read interface, and `full`/`empty` go back to the FSM and synchroniser.

## Interface
- `DEPTH`, 16: storage entries; power of two, 4..64.
- `AW`, 4: address width; must equal log2(`DEPTH`).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `soft_reset`  in  1  synchronous, active-high flush from the synchroniser's read timeout; same effect as `reset`.
- `write_enb`  in  1  write request from the synchroniser.
- `read_enb`  in  1  read request from the destination.
- `lfd_state`  in  1  marks the current `data_in` byte as a header; stored as bit 8 of the entry.
- `data_in`  in  8  byte from the register stage.
- `data_out`  out  8  registered read data.
- `full`  out  1  all `DEPTH` entries occupied.
- `empty`  out  1  no entries occupied.
- `pkt_active`  out  1  high while `pkt_cnt` is not 0.
- `ovf_err`  out  1  sticky misuse flag; see Configuration.

## Operation
- Storage: `DEPTH` x 9-bit array. Bit 8 is the header tag and bits 7:0 are data.
- Pointers: `wr_ptr` and `rd_ptr` are each `AW+1` bits and wrap naturally.
  - `empty` = (`wr_ptr` == `rd_ptr`).
  - `full` = MSBs differ and the low `AW` bits are equal.
  - Both flags are combinational from the registered pointers.
- Write: when `write_enb && !full`, store {`lfd_state`, `data_in`} at `wr_ptr[AW-1:0]`, then increment `wr_ptr`. A write attempted while full is dropped and the pointer is unchanged.
- Read: when `read_enb && !empty`, set `data_out` to entry[7:0] at `rd_ptr`, then increment `rd_ptr`. With no read, `data_out` holds its value.
- Simultaneous read and write:
  - Neither full nor empty: both proceed and occupancy is unchanged.
  - Full: the read proceeds and the write is dropped, because `full` is sampled before the edge.
  - Empty: the write proceeds and the read is ignored.
- Packet counter `pkt_cnt` (6 bits) updates on accepted reads only:
  - Entry tagged as header: `pkt_cnt` = entry[7:2] + 1 (payload plus parity byte).
  - Otherwise, if `pkt_cnt` is not 0: decrement `pkt_cnt`.
  - Header with length 63: `pkt_cnt` = 0 after 6-bit wrap, so `pkt_active` stays low. This is accepted behaviour; the register stage never forwards that length.
- Reset and `soft_reset` have identical effect; `reset` has priority. They clear:
  - both pointers;
  - `pkt_cnt`;
  - `data_out` to 8'h00;
  - `ovf_err`.
  - Array contents are not cleared.
  - Effect: `empty`=1, `full`=0, `pkt_active`=0 on the next cycle. A `soft_reset` mid-packet discards all buffered bytes; a write or read in the same cycle is ignored.

## Timing
- Write-to-visible latency is 1 cycle: `empty` falls in the cycle after the first accepted write.
- Read latency is 1 cycle: `data_out` is valid in the cycle after `read_enb && !empty`.
- `full` rises in the cycle after the `DEPTH`-th accepted write. It falls in the cycle after the first accepted read.
- `pkt_active` updates in the same cycle as the corresponding `data_out`.
- Output values after reset:
  - `data_out` = 8'h00;
  - `full` = 0;
  - `empty` = 1;
  - `pkt_active` = 0;
  - `ovf_err` = 0.

## Configuration
- Macro `ROUTER_FIFO_ERR_CHK_EN`.
- Defined: `ovf_err` is set on any write attempted while full, or any read attempted while empty. It stays set until `reset` or `soft_reset`.
- Undefined: `ovf_err` is tied to 0 and no checking logic is built. Functional behaviour is otherwise identical.

## Test plan
- Reset, then write header 8'h0D (length 3, tagged) and bytes 8'hA1, 8'hA2, 8'hA3, 8'h5F, then read 5 times.
  - Required: `data_out` = 0D, A1, A2, A3, 5F.
  - Required: `pkt_active` high from the header read through the byte before parity is shown; `pkt_cnt` = 4, 3, 2, 1, 0.
  - Required: `empty` = 1 after the 5th read.
- Write 16 bytes 8'h00..8'h0F, then attempt a 17th write of 8'hFF.
  - Required: `full` = 1; the 8'hFF write is dropped.
  - Required: 16 reads return 00..0F.
  - Required: `ovf_err` = 1 with the macro defined, 0 without it.
- With 8 entries held, assert read and write together for 20 cycles.
  - Required: occupancy stays 8 and pointers wrap past 31 to 0.
  - Required: data order is preserved.
- With `full` = 1, assert read and write together.
  - Required: the read returns the oldest byte and the write is dropped.
  - Required: `full` = 0 the next cycle.
- Pulse `soft_reset` mid-packet with 6 entries held.
  - Required next cycle: `empty` = 1, `data_out` = 8'h00, `pkt_active` = 0.
  - Required: a subsequent write and read of 8'h3C returns 8'h3C.
- With `empty` = 1, issue a read.
  - Required: `data_out` unchanged and pointers unchanged.
  - Required: `ovf_err` = 1 when the macro is defined.
